// File: rtl/lnx_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : lnx_feeder_if
// Purpose  : Producer-stream and core-launch signals of the ln-core feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface lnx_feeder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] operand;
  logic             start;
  logic             core_ready;
  logic             core_valid;

  // slave: the feeder itself; master: the surrounding producer and core
  modport slave (
    input  din, din_valid, core_ready, core_valid,
    output din_ready, operand, start
  );

  modport master (
    output din, din_valid, core_ready, core_valid,
    input  din_ready, operand, start
  );
endinterface
`default_nettype wire

// File: rtl/lnx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : lnx_feeder
// Purpose  : FIFO-buffered operand feeder issuing one START per sample to the
//            natural-log core. LNX_FEEDER_ZERO_FILTER_EN drops zero operands.
// Revision : 1.0 - initial release
// ============================================================================
module lnx_feeder #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     resetstage,
  lnx_feeder_if.slave                   bus,
  output logic                          busy,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_operand;
  logic             r_start;
  logic             r_drop;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_launch;
  logic             w_drop;
  logic             w_head_zero;
  logic [WIDTH-1:0] w_head;

  assign w_full        = (r_count == C_FULL);
  assign w_empty       = (r_count == '0);
  assign w_push        = bus.din_valid && !w_full;
  assign w_pop         = w_launch || w_drop;
  assign w_head        = r_mem[r_rd_ptr];

`ifdef LNX_FEEDER_ZERO_FILTER_EN
  assign w_head_zero   = (w_head == '0);
`else
  assign w_head_zero   = 1'b0;
`endif

  assign bus.din_ready = !w_full;
  assign bus.operand   = r_operand;
  assign bus.start     = r_start;
  assign busy          = (r_state == S_BUSY);
  assign count         = r_count;
  assign drop          = r_drop;

  // Launch and drop are only ever decided in IDLE, so no pop happens while busy
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if (w_head_zero) begin
            w_drop = 1'b1;
          end else if (bus.core_ready) begin
            w_launch    = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (bus.core_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetstage) begin
    if (!resetstage) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Storage carries no reset; entries are only read when COUNT says they are valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge resetstage) begin
    if (!resetstage) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetstage) begin
    if (!resetstage) begin
      r_operand <= '0;
      r_start   <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_start <= w_launch;
      r_drop  <= w_drop;
      if (w_launch) begin
        r_operand <= w_head;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lnx_feeder.sv
`default_nettype none
// Directed bench for lnx_feeder: a scoreboard queue holds the operands expected
// at each START; compile with LNX_FEEDER_ZERO_FILTER_EN to exercise the filter.
`timescale 1ns/1ps
module tb_lnx_feeder;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             resetstage;
  logic             busy;
  logic [CW-1:0]    count;
  logic             drop;

  lnx_feeder_if #(.WIDTH(WIDTH)) bus();

  lnx_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .resetstage (resetstage),
    .bus        (bus),
    .busy       (busy),
    .count      (count),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  int               n_checks   = 0;
  int               n_fail     = 0;
  int               drops_seen = 0;
  int               drops_base = 0;
  logic             prev_start = 1'b0;
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] exp_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] v, input bit expect_launch);
    bus.din       = v;
    bus.din_valid = 1'b1;
    if (expect_launch) sb.push_back(v);
    tick();
    bus.din_valid = 1'b0;
  endtask

  // Acts as the core for n operations: wait for START, answer VALID one cycle later
  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (bus.start !== 1'b1 && t < 30) begin
        tick();
        t++;
      end
      chk("serve_start", 32'(bus.start), 32'd1);
      tick();
      chk("start_one_cycle", 32'(bus.start), 32'd0);
      chk("busy_hold", 32'(busy), 32'd1);
      bus.core_valid = 1'b1;
      tick();
      bus.core_valid = 1'b0;
      chk("busy_fall", 32'(busy), 32'd0);
    end
  endtask

  // Output monitor: every START must match the oldest scoreboard entry
  always @(negedge clk) begin
    if (resetstage !== 1'b1) begin
      prev_start = 1'b0;
    end else begin
      if (bus.start === 1'b1) begin
        chk("start_gap", 32'(prev_start), 32'd0);
        chk("start_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_op = sb.pop_front();
          chk("operand_order", 32'(bus.operand), 32'(exp_op));
        end
      end
      if (drop === 1'b1) drops_seen++;
      prev_start = bus.start;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetstage     = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.core_ready = 1'b1;
    bus.core_valid = 1'b0;
    tick();
    tick();
    chk("rst_din_ready", 32'(bus.din_ready), 32'd1);
    chk("rst_operand", 32'(bus.operand), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    resetstage = 1'b1;
    tick();

    // Single sample: push at E0, START for exactly E1..E2
    push(16'h0100, 1'b1);
    chk("t1_no_start_e0", 32'(bus.start), 32'd0);
    chk("t1_count_e0", 32'(count), 32'd1);
    tick();
    chk("t1_start_e1", 32'(bus.start), 32'd1);
    chk("t1_busy_e1", 32'(busy), 32'd1);
    chk("t1_operand_e1", 32'(bus.operand), 32'h0100);
    chk("t1_count_e1", 32'(count), 32'd0);
    tick();
    chk("t1_start_e2", 32'(bus.start), 32'd0);
    chk("t1_operand_held", 32'(bus.operand), 32'h0100);
    bus.core_valid = 1'b1;
    tick();
    bus.core_valid = 1'b0;
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_operand_after", 32'(bus.operand), 32'h0100);

    // Fill while the core is stalled; the fifth sample must be refused
    bus.core_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(WIDTH'(i), i <= 4);
    chk("t2_count_full", 32'(count), 32'd4);
    chk("t2_din_ready_full", 32'(bus.din_ready), 32'd0);
    bus.core_ready = 1'b1;
    serve(4);
    chk("t2_count_drained", 32'(count), 32'd0);
    chk("t2_din_ready_back", 32'(bus.din_ready), 32'd1);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Push concurrent with launch at COUNT=3, then 10 samples across wrap
    bus.core_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(WIDTH'(16'h0010 + k), 1'b1);
    chk("t3_count3", 32'(count), 32'd3);
    bus.core_ready = 1'b1;
    push(16'h0013, 1'b1);
    chk("t3_count_concurrent", 32'(count), 32'd3);
    chk("t3_start_concurrent", 32'(bus.start), 32'd1);
    serve(1);
    for (int k = 4; k < 10; k++) begin
      push(WIDTH'(16'h0010 + k), 1'b1);
      serve(1);
    end
    serve(3);
    chk("t3_count_end", 32'(count), 32'd0);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // CORE_VALID while idle and empty is ignored
    bus.core_valid = 1'b1;
    tick();
    bus.core_valid = 1'b0;
    tick();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_start", 32'(bus.start), 32'd0);
    chk("t4_count", 32'(count), 32'd0);

    // Zero operand followed by 5
    drops_base = drops_seen;
`ifdef LNX_FEEDER_ZERO_FILTER_EN
    push(16'h0000, 1'b0);
    push(16'h0005, 1'b1);
    chk("t5_drop_pulse", 32'(drop), 32'd1);
    chk("t5_no_start_zero", 32'(bus.start), 32'd0);
    serve(1);
    chk("t5_drop_count", 32'(drops_seen - drops_base), 32'd1);
`else
    push(16'h0000, 1'b1);
    push(16'h0005, 1'b1);
    chk("t5_drop_low", 32'(drop), 32'd0);
    chk("t5_start_zero", 32'(bus.start), 32'd1);
    serve(2);
    chk("t5_drop_count", 32'(drops_seen - drops_base), 32'd0);
`endif
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Reset between START and CORE_VALID with two samples buffered
    push(16'h00A1, 1'b1);
    push(16'h00A2, 1'b1);
    push(16'h00A3, 1'b1);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    chk("t6_count_pre", 32'(count), 32'd2);
    sb.delete();
    resetstage = 1'b0;
    #1;
    chk("t6_busy_async", 32'(busy), 32'd0);
    chk("t6_start_async", 32'(bus.start), 32'd0);
    chk("t6_count_async", 32'(count), 32'd0);
    chk("t6_din_ready_async", 32'(bus.din_ready), 32'd1);
    tick();
    tick();
    resetstage = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_start_after", 32'(bus.start), 32'd0);
    chk("t6_busy_after", 32'(busy), 32'd0);
    chk("t6_count_after", 32'(count), 32'd0);
    push(16'h0042, 1'b1);
    serve(1);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
